// File: rtl/gpu_mem_cpuvram_unpack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gpu_mem_cpuvram_unpack : splits GP0 A0h data words into addressed pixels  |
// | Optional: GPU_CPUVRAM_MASK_EN forces pixel bit15 from the E6h mask latch  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module gpu_mem_cpuvram_unpack #(
  parameter int FIFO_W = 35,
  parameter int CNT_W  = 20
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [9:0]        rect_x_i,
  input  logic [8:0]        rect_y_i,
  input  logic [9:0]        rect_w_i,
  input  logic [8:0]        rect_h_i,
  input  logic              set_mask_i,
  input  logic              abort_i,
  input  logic [31:0]       word_i,
  input  logic              word_valid_i,
  output logic              word_ready_o,
  output logic [FIFO_W-1:0] fifo_data_o,
  output logic              fifo_push_o,
  input  logic              fifo_accept_i,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_EMIT_LO = 2'd2,
    S_EMIT_HI = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [9:0]       r_x0;
  logic [8:0]       r_y0;
  logic [10:0]      r_w;
  logic [9:0]       r_col;
  logic [8:0]       r_row;
  logic [CNT_W-1:0] r_rem;
  logic [31:0]      r_hold;
  logic             r_done;

  logic             w_emit;
  logic             w_acc;
  logic             w_last;
  logic             w_col_wrap;
  logic [9:0]       w_x;
  logic [8:0]       w_y;
  logic [15:0]      w_pix_raw;
  logic [15:0]      w_pix;
  logic [10:0]      w_w_eff;
  logic [9:0]       w_h_eff;
  logic [CNT_W-1:0] w_area;

  // Zero-sized dimensions encode the full VRAM extent.
  assign w_w_eff = (rect_w_i == 10'd0) ? 11'd1024 : {1'b0, rect_w_i};
  assign w_h_eff = (rect_h_i == 9'd0)  ? 10'd512  : {1'b0, rect_h_i};
  assign w_area  = {{(CNT_W-11){1'b0}}, w_w_eff} * {{(CNT_W-10){1'b0}}, w_h_eff};

  assign w_emit     = (r_state == S_EMIT_LO) || (r_state == S_EMIT_HI);
  assign w_acc      = w_emit && fifo_accept_i;
  assign w_last     = w_acc && (r_rem == c_one);
  assign w_col_wrap = (({1'b0, r_col} + 11'd1) == r_w);

  // Coordinates wrap naturally through 10/9-bit truncation.
  assign w_x       = r_x0 + r_col;
  assign w_y       = r_y0 + r_row;
  assign w_pix_raw = (r_state == S_EMIT_HI) ? r_hold[31:16] : r_hold[15:0];

`ifdef GPU_CPUVRAM_MASK_EN
  logic r_mask;
  assign w_pix = {w_pix_raw[15] | r_mask, w_pix_raw[14:0]};
`else
  logic w_unused_mask;
  assign w_unused_mask = set_mask_i;
  assign w_pix         = w_pix_raw;
`endif

  assign fifo_data_o  = {w_y, w_x, w_pix};
  assign fifo_push_o  = w_emit;
  assign word_ready_o = (r_state == S_FETCH);
  assign busy_o       = (r_state != S_IDLE);
  assign done_o       = r_done;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (start_i) w_state_nxt = S_FETCH;
      S_FETCH:   if (word_valid_i) w_state_nxt = S_EMIT_LO;
      S_EMIT_LO: if (w_acc) w_state_nxt = w_last ? S_IDLE : S_EMIT_HI;
      S_EMIT_HI: if (w_acc) w_state_nxt = w_last ? S_IDLE : S_FETCH;
      default:   w_state_nxt = S_IDLE;
    endcase
    if (abort_i) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_x0   <= '0;
      r_y0   <= '0;
      r_w    <= '0;
      r_col  <= '0;
      r_row  <= '0;
      r_rem  <= '0;
      r_hold <= '0;
      r_done <= 1'b0;
`ifdef GPU_CPUVRAM_MASK_EN
      r_mask <= 1'b0;
`endif
    end else begin
      r_done <= w_last && !abort_i;
      if (!abort_i) begin
        if ((r_state == S_IDLE) && start_i) begin
          r_x0  <= rect_x_i;
          r_y0  <= rect_y_i;
          r_w   <= w_w_eff;
          r_rem <= w_area;
          r_col <= '0;
          r_row <= '0;
`ifdef GPU_CPUVRAM_MASK_EN
          r_mask <= set_mask_i;
`endif
        end
        if ((r_state == S_FETCH) && word_valid_i) r_hold <= word_i;
        if (w_acc) begin
          r_rem <= r_rem - c_one;
          if (w_col_wrap) begin
            r_col <= '0;
            r_row <= r_row + 9'd1;
          end else begin
            r_col <= r_col + 10'd1;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gpu_mem_cpuvram_unpack.sv
`default_nettype none
// Scoreboard bench for gpu_mem_cpuvram_unpack: random rectangles against a
// pixel-index reference model, plus reset/abort/wrap/backpressure corners.
module tb_gpu_mem_cpuvram_unpack;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [9:0]  rect_x_i = '0;
  logic [8:0]  rect_y_i = '0;
  logic [9:0]  rect_w_i = '0;
  logic [8:0]  rect_h_i = '0;
  logic        set_mask_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [31:0] word_i = '0;
  logic        word_valid_i = 1'b0;
  logic        word_ready_o;
  logic [34:0] fifo_data_o;
  logic        fifo_push_o;
  logic        fifo_accept_i = 1'b0;
  logic        busy_o;
  logic        done_o;

  always #5 clk = ~clk;

  gpu_mem_cpuvram_unpack dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .rect_x_i(rect_x_i), .rect_y_i(rect_y_i), .rect_w_i(rect_w_i), .rect_h_i(rect_h_i),
    .set_mask_i(set_mask_i), .abort_i(abort_i),
    .word_i(word_i), .word_valid_i(word_valid_i), .word_ready_o(word_ready_o),
    .fifo_data_o(fifo_data_o), .fifo_push_o(fifo_push_o), .fifo_accept_i(fifo_accept_i),
    .busy_o(busy_o), .done_o(done_o)
  );

  int          n_tests = 0;
  int          n_fail = 0;
  logic [34:0] sb_q[$];
  logic [31:0] g_words[$];
  int          acc_cnt = 0;
  int          word_cnt = 0;
  int          done_cnt = 0;
  int          accept_mode = 0;
  int          acc_limit = 0;
  logic        prev_stall = 1'b0;
  logic        prev_rst = 1'b1;
  logic        prev_abort = 1'b0;
  logic [34:0] prev_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Pixel i of the rectangle comes from word i/2 (low half first) and lands
  // at column i%W, row i/W relative to the origin, wrapped to VRAM size.
  function automatic void build_expected(input int x, input int y, input int w_eff,
                                         input bit msk, input int count);
    logic [31:0] wd;
    logic [15:0] p;
    int          xx;
    int          yy;
    for (int i = 0; i < count; i++) begin
      wd = g_words[i/2];
      p  = (i % 2 == 1) ? wd[31:16] : wd[15:0];
`ifdef GPU_CPUVRAM_MASK_EN
      if (msk) p[15] = 1'b1;
`endif
      xx = (x + i % w_eff) % 1024;
      yy = (y + i / w_eff) % 512;
      sb_q.push_back({yy[8:0], xx[9:0], p});
    end
  endfunction

  // Monitor: pops the scoreboard on every accepted push, checks stall stability.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (prev_stall && !prev_rst && !prev_abort) begin
        check("stall_push_held", {63'd0, fifo_push_o}, 64'd1);
        check("stall_data_held", {29'd0, fifo_data_o}, {29'd0, prev_data});
      end
      if (fifo_push_o && fifo_accept_i) begin
        acc_cnt++;
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_push: got 0x%0h expected no push", fifo_data_o);
        end else begin
          check("pixel", {29'd0, fifo_data_o}, {29'd0, sb_q.pop_front()});
        end
      end
      if (word_valid_i && word_ready_o) word_cnt++;
      if (done_o) begin
        done_cnt++;
        check("done_sb_empty", 64'(sb_q.size()), 64'd0);
        check("done_not_busy", {63'd0, busy_o}, 64'd0);
      end
    end
    prev_stall = fifo_push_o && !fifo_accept_i;
    prev_data  = fifo_data_o;
    prev_rst   = rst_i;
    prev_abort = abort_i;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (accept_mode)
        0:       fifo_accept_i = 1'b1;
        1:       fifo_accept_i = ($urandom_range(0, 3) != 0);
        2:       fifo_accept_i = ~fifo_accept_i;
        default: fifo_accept_i = (acc_cnt < acc_limit);
      endcase
    end
  end

  task automatic feed(input int nw, output bit ok);
    int guard;
    ok = 1'b1;
    for (int k = 0; k < nw; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        word_valid_i = 1'b0;
        @(posedge clk);
        #1;
      end
      word_i       = g_words[k];
      word_valid_i = 1'b1;
      guard        = 0;
      forever begin
        @(negedge clk);
        if (word_ready_o) break;
        guard++;
        if (guard > 5000) begin
          ok = 1'b0;
          break;
        end
      end
      @(posedge clk);
      #1;
      if (!ok) break;
    end
    word_valid_i = 1'b0;
  endtask

  task automatic do_start(input int x, input int y, input int w, input int h, input bit msk);
    rect_x_i   = 10'(x);
    rect_y_i   = 9'(y);
    rect_w_i   = 10'(w);
    rect_h_i   = 9'(h);
    set_mask_i = msk;
    start_i    = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic run_xfer(input int x, input int y, input int w, input int h,
                          input bit msk, input bit user_words, input int amode);
    int w_eff;
    int h_eff;
    int n_pix;
    int n_words;
    int d0;
    int w0;
    int t;
    bit ok;
    w_eff   = (w == 0) ? 1024 : w;
    h_eff   = (h == 0) ? 512 : h;
    n_pix   = w_eff * h_eff;
    n_words = (n_pix + 1) / 2;
    if (!user_words) begin
      g_words.delete();
      for (int i = 0; i < n_words; i++) g_words.push_back($urandom);
    end
    build_expected(x, y, w_eff, msk, n_pix);
    accept_mode = amode;
    d0 = done_cnt;
    w0 = word_cnt;
    do_start(x, y, w, h, msk);
    feed(n_words, ok);
    check("words_fed_in_time", {63'd0, ok}, 64'd1);
    t = 0;
    while (done_cnt == d0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", 64'(done_cnt - d0), 64'd1);
    check("words_consumed", 64'(word_cnt - w0), 64'(n_words));
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    check("idle_after", {63'd0, busy_o}, 64'd0);
    sb_q.delete();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int w0;
    int a0;
    int t;
    bit ok;
    int rw;
    int rh;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {63'd0, busy_o}, 64'd0);
    check("rst_push", {63'd0, fifo_push_o}, 64'd0);
    check("rst_ready", {63'd0, word_ready_o}, 64'd0);
    check("rst_done", {63'd0, done_o}, 64'd0);
    check("rst_data", {29'd0, fifo_data_o}, 64'd0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(posedge clk);
    #1;

    g_words.delete();
    g_words.push_back(32'h8001_7FFF);
    run_xfer(10, 20, 2, 1, 1'b0, 1'b1, 0);

    g_words.delete();
    g_words.push_back(32'h0002_0001);
    g_words.push_back(32'h0004_0003);
    g_words.push_back(32'h0006_0005);
    run_xfer(0, 0, 3, 2, 1'b0, 1'b1, 0);

    run_xfer(1023, 511, 2, 2, 1'b0, 1'b0, 2);

    g_words.delete();
    g_words.push_back(32'hBEEF_1234);
    run_xfer(5, 6, 1, 1, 1'b0, 1'b1, 0);

    run_xfer(int'($urandom_range(0, 1023)), 300, 0, 1, 1'b0, 1'b0, 1);

    for (int n = 0; n < 10; n++) begin
      rw = int'($urandom_range(1, 7));
      rh = int'($urandom_range(1, 4));
      run_xfer(int'($urandom_range(1015, 1023)), int'($urandom_range(505, 511)), rw, rh,
               1'($urandom_range(0, 1)), 1'b0, int'($urandom_range(0, 2)));
    end

    // Abort after three of six pixels, while the fourth is stalled.
    g_words.delete();
    for (int i = 0; i < 3; i++) g_words.push_back($urandom);
    build_expected(5, 7, 3, 1'b0, 3);
    a0 = acc_cnt;
    d0 = done_cnt;
    w0 = word_cnt;
    acc_limit   = a0 + 3;
    accept_mode = 3;
    do_start(5, 7, 3, 2, 1'b0);
    feed(2, ok);
    check("abort_words_fed", {63'd0, ok}, 64'd1);
    t = 0;
    while (acc_cnt < a0 + 3 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    #1;
    abort_i = 1'b1;
    @(posedge clk);
    #1;
    abort_i = 1'b0;
    @(negedge clk);
    check("abort_busy", {63'd0, busy_o}, 64'd0);
    check("abort_push", {63'd0, fifo_push_o}, 64'd0);
    check("abort_ready", {63'd0, word_ready_o}, 64'd0);
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    check("abort_pixels", 64'(acc_cnt - a0), 64'd3);
    check("abort_words", 64'(word_cnt - w0), 64'd2);
    sb_q.delete();

    run_xfer(100, 200, 3, 2, 1'b0, 1'b0, 1);

    g_words.delete();
    g_words.push_back(32'h0000_1234);
    run_xfer(0, 0, 1, 1, 1'b1, 1'b1, 0);

    // Reset while the low half is presented but not accepted.
    acc_limit   = acc_cnt;
    accept_mode = 3;
    g_words.delete();
    g_words.push_back(32'h5555_AAAA);
    do_start(40, 50, 2, 1, 1'b0);
    feed(1, ok);
    @(negedge clk);
    check("pre_rst_push", {63'd0, fifo_push_o}, 64'd1);
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    check("midrst_push", {63'd0, fifo_push_o}, 64'd0);
    check("midrst_busy", {63'd0, busy_o}, 64'd0);
    check("midrst_done", {63'd0, done_o}, 64'd0);
    check("midrst_ready", {63'd0, word_ready_o}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gpu_mem_cpuvram_unpack.md
Name: gpu_mem_cpuvram_unpack

Overview:
- Upstream feeder of the CPU->VRAM pixel FIFO for the GP0 CPU-to-VRAM copy command (A0h).
- Takes 32-bit GP0 data words and splits each into two 16-bit pixels, low half first.
- Walks the destination rectangle row-major, attaching a wrapped VRAM (x,y) coordinate to every pixel.
- Pushes {y,x,pixel} entries into the FIFO with push/accept handshake; signals completion when the rectangle is exhausted.

Parameters:
- FIFO_W, 35, width of a FIFO entry = 9 (y) + 10 (x) + 16 (pixel); fixed packing, must stay 35.
- CNT_W, 20, width of remaining-pixel counter (max 1024*512 = 2^19 pixels).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  one-cycle pulse: latch rectangle and begin transfer; ignored while busy_o=1
- rect_x_i  in  10  destination X (VRAM 0..1023)
- rect_y_i  in  9  destination Y (VRAM 0..511)
- rect_w_i  in  10  width; 0 encodes 1024
- rect_h_i  in  9  height; 0 encodes 512
- set_mask_i  in  1  GP0 E6h bit0 force-mask; sampled at start_i (used only with optional feature)
- abort_i  in  1  drop current transfer, return to idle
- word_i  in  32  GP0 data word
- word_valid_i  in  1  word_i valid
- word_ready_o  out  1  word consumed this cycle when word_valid_i & word_ready_o
- fifo_data_o  out  35  {y[8:0], x[9:0], pixel[15:0]} (bits 34:26, 25:16, 15:0)
- fifo_push_o  out  1  entry valid
- fifo_accept_i  in  1  FIFO can accept (push completes when fifo_push_o & fifo_accept_i)
- busy_o  out  1  transfer in progress
- done_o  out  1  one-cycle pulse after last pixel accepted

Behaviour:
- States: IDLE, FETCH, EMIT_LO, EMIT_HI. Reset -> IDLE; all outputs 0; col/row/remaining/holding register cleared.
- IDLE: busy_o=0. On start_i: latch x0,y0; W=(rect_w_i==0)?1024:rect_w_i; H=(rect_h_i==0)?512:rect_h_i; remaining=W*H; col=0,row=0; mask latch=set_mask_i; -> FETCH next cycle.
- FETCH: word_ready_o=1 (only in this state). On word_valid_i: store word_i in holding reg -> EMIT_LO.
- EMIT_LO: fifo_push_o=1, pixel=hold[15:0]. On accept: advance position, remaining-=1; if remaining was 1 -> IDLE, done_o=1 next cycle, hold[31:16] discarded; else -> EMIT_HI.
- EMIT_HI: fifo_push_o=1, pixel=hold[31:16]. On accept: advance, remaining-=1; if remaining was 1 -> IDLE with done_o pulse; else -> FETCH.
- Position advance: col+1; if col+1==W then col=0, row+1. x=(x0+col)&0x3FF, y=(y0+row)&0x1FF (modulo VRAM wrap, 10/9-bit truncation).
- fifo_data_o held stable while fifo_push_o=1 and not accepted; fifo_push_o never drops without accept (except abort/reset).
- Throughput: 3 cycles per word with no backpressure (FETCH, LO, HI); fifo_accept_i=0 stalls in EMIT state indefinitely.
- done_o: registered, high exactly one cycle, in the cycle after the final accept; busy_o=0 in that same cycle.
- abort_i: highest priority after reset; any state -> IDLE next cycle, no done_o, no further push or word consumption; a push accepted in the abort cycle still counts as delivered.
- start_i and abort_i same cycle in IDLE: abort wins, stay IDLE.
- Rows never split words: pixel stream is contiguous across row boundaries (a word may carry last pixel of row r and first of row r+1).

Optional Feature:
- Macro GPU_CPUVRAM_MASK_EN.
- Defined: emitted pixel[15] = word_bit15 | mask latch (sampled at start_i).
- Undefined: pixel bits passed unchanged; set_mask_i ignored (port retained).

Test Plan:
- Reset mid-EMIT_LO with fifo_accept_i=0 -> next cycle fifo_push_o=0, busy_o=0, done_o=0, word_ready_o=0.
- start x=10,y=20,w=2,h=1; word 0x8001_7FFF; accept=1 -> pushes {20,10,0x7FFF},{20,11,0x8001}; done_o one cycle later; exactly 1 word consumed.
- w=3,h=2 at (0,0); 3 words 0x0002_0001,0x0004_0003,0x0006_0005 -> (0,0)=1,(1,0)=2,(2,0)=3,(0,1)=4,(1,1)=5,(2,1)=6; done after 6th.
- x=1023,y=511,w=2,h=2; accept toggling 1/0 each cycle -> coords (1023,511),(0,511),(1023,0),(0,0); data stable during stalls; no loss/duplication.
- w=1,h=1; word 0xBEEF_1234 -> single push 0x1234, high half dropped; rect_w_i=0,rect_h_i=1 -> 1024 pushes, 512 words, last x=(x0+1023)&0x3FF.
- Abort after 3 of 6 pixels -> IDLE, no done_o; new start then runs cleanly. With GPU_CPUVRAM_MASK_EN and set_mask_i=1, word 0x0000_1234 -> pixel 0x9234.
